// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {HOLD, DOWN, RISE, UP, FALL} state_t;

  // Width of the stage counter for n sequenced outputs.
  function automatic int stage_bits(input int n);
    return $clog2(n + 1);
  endfunction

  // A step delay of zero would stall the timer, so it behaves as one cycle.
  function automatic logic [31:0] clamp_delay(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter: counts to zero and stays there; expire flags value==1.
module reset_seq_timer #(
  parameter int             W       = 16,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o  = cnt_q;
  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Releases reset domains 0..N-1 and asserts them N-1..0, one step per delay period,
// with a minimum all-asserted hold. RESET_SEQUENCER_ACK_EN gates each release on the previous domain's ack.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int C_OUTPUT_COUNT = 4,
  parameter int C_DELAY_WIDTH  = 16,
  parameter int C_HOLD_CYCLES  = 16
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 req_run,
  input  logic [C_DELAY_WIDTH-1:0]             step_delay,
`ifdef RESET_SEQUENCER_ACK_EN
  input  logic [C_OUTPUT_COUNT-1:0]            domain_ready,
`endif
  output logic [C_OUTPUT_COUNT-1:0]            out_aresetn,
  output logic [$clog2(C_OUTPUT_COUNT+1)-1:0]  stage,
  output logic                                 up,
  output logic                                 down,
  output logic                                 busy
);

  localparam int SW = stage_bits(C_OUTPUT_COUNT);
  localparam int HW = $clog2(C_HOLD_CYCLES + 1);
  localparam int TW = (C_DELAY_WIDTH > HW) ? C_DELAY_WIDTH : HW;
  localparam logic [TW-1:0]             HOLD_VAL = TW'(C_HOLD_CYCLES);
  localparam logic [SW-1:0]             FULL     = SW'(C_OUTPUT_COUNT);
  localparam logic [C_OUTPUT_COUNT-1:0] BIT0     = C_OUTPUT_COUNT'(1);

  state_t                    state_q, state_d;
  logic [SW-1:0]             stage_q, stage_d;
  logic [C_OUTPUT_COUNT-1:0] out_q, out_d;
  logic                      up_q, down_q, busy_q;
  logic                      tmr_load, tmr_exp, tmr_zero, ack_top;
  logic [TW-1:0]             tmr_val, tmr_value, dly;

  assign dly      = TW'(clamp_delay(32'(step_delay)));
  assign tmr_zero = (tmr_value == '0);

`ifdef RESET_SEQUENCER_ACK_EN
  localparam bit ACK_EN = 1'b1;
  // out_q is a thermometer code, so this isolates the most recently released domain.
  assign ack_top = |(domain_ready & (out_q ^ (out_q >> 1)));
`else
  localparam bit ACK_EN = 1'b0;
  assign ack_top = 1'b1;
`endif

  reset_seq_timer #(.W(TW), .RST_VAL(HOLD_VAL)) u_timer (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_value),
    .expire_o   (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    out_d    = out_q;
    tmr_load = 1'b0;
    tmr_val  = dly;
    case (state_q)
      HOLD: if (tmr_exp) state_d = DOWN;
      DOWN: if (req_run) begin
        tmr_load = 1'b1;
        state_d  = RISE;
      end
      RISE: begin
        if (!req_run) begin
          tmr_load = 1'b1;
          if (stage_q == '0) begin
            tmr_val = HOLD_VAL;
            state_d = HOLD;
          end else begin
            state_d = FALL;
          end
        end else if (tmr_zero) begin
          // Only reachable while a release waits for its domain's ack.
          if (ack_top) begin
            if (stage_q == FULL) state_d = UP;
            else                 tmr_load = 1'b1;
          end
        end else if (tmr_exp) begin
          out_d   = (out_q << 1) | BIT0;
          stage_d = stage_q + SW'(1);
          if (!ACK_EN) begin
            if (stage_q == FULL - SW'(1)) state_d = UP;
            else                          tmr_load = 1'b1;
          end
        end
      end
      UP: if (!req_run) begin
        tmr_load = 1'b1;
        state_d  = FALL;
      end
      FALL: begin
        if (req_run) begin
          tmr_load = 1'b1;
          state_d  = RISE;
        end else if (tmr_exp) begin
          out_d    = out_q >> 1;
          stage_d  = stage_q - SW'(1);
          tmr_load = 1'b1;
          if (stage_q == SW'(1)) begin
            tmr_val = HOLD_VAL;
            state_d = HOLD;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= HOLD;
      stage_q <= '0;
      out_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      out_q   <= out_d;
      up_q    <= (state_d == UP);
      down_q  <= (state_d == DOWN);
      busy_q  <= !((state_d == UP) || (state_d == DOWN));
    end
  end

  assign out_aresetn = out_q;
  assign stage       = stage_q;
  assign up          = up_q;
  assign down        = down_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: event-time model checked every cycle plus pinned literal expectations.
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int HOLD = 16;
  localparam int P_HOLD = 0, P_DOWN = 1, P_RISE = 2, P_UP = 3, P_FALL = 4;

  logic          aclk       = 1'b0;
  logic          aresetn    = 1'b0;
  logic          req_run    = 1'b1;
  logic [DW-1:0] step_delay = 16'd3;
`ifdef RESET_SEQUENCER_ACK_EN
  logic [N-1:0]  domain_ready = 4'b1101;
`endif
  logic [N-1:0]  out_aresetn;
  logic [2:0]    stage;
  logic          up, down, busy;

  int ecount = 0;
  int nchk   = 0;
  int nerr   = 0;
  bit chk_en = 1'b0;

  int m_n    = 0;
  int m_ph   = P_HOLD;
  int m_due  = 1 << 30;
  bit m_wait = 1'b0;

  reset_sequencer #(.C_OUTPUT_COUNT(N), .C_DELAY_WIDTH(DW), .C_HOLD_CYCLES(HOLD)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_run     (req_run),
    .step_delay  (step_delay),
`ifdef RESET_SEQUENCER_ACK_EN
    .domain_ready(domain_ready),
`endif
    .out_aresetn (out_aresetn),
    .stage       (stage),
    .up          (up),
    .down        (down),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) ecount <= ecount + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  task automatic at_edge(input int e);
    while (ecount < e) @(negedge aclk);
  endtask

  // Model: tracks released count and the absolute edge of the next scheduled step.
  always @(posedge aclk or negedge aresetn) begin
    int e, d;
    bit rdy;
    e = aclk ? ecount + 1 : ecount;
    if (!aresetn) begin
      m_n = 0; m_ph = P_HOLD; m_wait = 1'b0; m_due = e + HOLD;
    end else begin
      d = (step_delay == '0) ? 1 : int'(step_delay);
      case (m_ph)
        P_HOLD: if (e == m_due) m_ph = P_DOWN;
        P_DOWN: if (req_run) begin m_ph = P_RISE; m_due = e + d; end
        P_RISE: begin
          if (!req_run) begin
            m_wait = 1'b0;
            if (m_n == 0) begin m_ph = P_HOLD; m_due = e + HOLD; end
            else begin m_ph = P_FALL; m_due = e + d; end
          end else if (m_wait) begin
`ifdef RESET_SEQUENCER_ACK_EN
            rdy = domain_ready[m_n-1];
`else
            rdy = 1'b1;
`endif
            if (rdy) begin
              m_wait = 1'b0;
              if (m_n == N) m_ph = P_UP; else m_due = e + d;
            end
          end else if (e == m_due) begin
            m_n++;
`ifdef RESET_SEQUENCER_ACK_EN
            m_wait = 1'b1;
`else
            if (m_n == N) m_ph = P_UP; else m_due = e + d;
`endif
          end
        end
        P_UP: if (!req_run) begin m_ph = P_FALL; m_due = e + d; end
        P_FALL: begin
          if (req_run) begin m_ph = P_RISE; m_due = e + d; end
          else if (e == m_due) begin
            m_n--;
            if (m_n == 0) begin m_ph = P_HOLD; m_due = e + HOLD; end
            else m_due = e + d;
          end
        end
        default: m_ph = P_HOLD;
      endcase
    end
  end

  always @(negedge aclk) begin
    logic [N-1:0] eo;
    logic [9:0]   ev;
    if (chk_en) begin
      eo = N'((1 << m_n) - 1);
      ev = {eo, 3'(m_n), m_ph == P_UP, m_ph == P_DOWN, !(m_ph == P_UP || m_ph == P_DOWN)};
      chk("cycle", {out_aresetn, stage, up, down, busy}, 32'(ev));
    end
  end

  initial begin
    int r, e0, f, g, h, s, r2;
    at_edge(2);
    chk("rst_out", out_aresetn, 0);
    chk("rst_stage", stage, 0);
    chk("rst_flags", {up, down, busy}, 3'b001);
    r = ecount;
    aresetn = 1'b1;
    chk_en  = 1'b1;
`ifdef RESET_SEQUENCER_ACK_EN
    at_edge(r + 20); chk("ack_b0", out_aresetn, 4'h1);
    at_edge(r + 23); chk("ack_b1_pre", out_aresetn, 4'h1);
    at_edge(r + 24); chk("ack_b1", out_aresetn, 4'h3);
    at_edge(r + 74); chk("ack_stall", out_aresetn, 4'h3);
    domain_ready = 4'b0111;
    at_edge(r + 77); chk("ack_b2_pre", out_aresetn, 4'h3);
    at_edge(r + 78); chk("ack_b2", out_aresetn, 4'h7);
    at_edge(r + 82); chk("ack_b3", out_aresetn, 4'hF); chk("ack_noup", up, 0);
    at_edge(r + 90); chk("ack_noup2", up, 0);
    domain_ready = 4'hF;
    at_edge(r + 91); chk("ack_up", up, 1);
    at_edge(r + 95);
`else
    // Power-up release with D=3.
    at_edge(r + 15); chk("p_hold15", down, 0);
    at_edge(r + 16); chk("p_down16", down, 1);
    at_edge(r + 19); chk("p_out19", out_aresetn, 4'h0);
    at_edge(r + 20); chk("p_out20", out_aresetn, 4'h1); chk("p_st20", stage, 1);
    at_edge(r + 23); chk("p_out23", out_aresetn, 4'h3);
    at_edge(r + 26); chk("p_out26", out_aresetn, 4'h7);
    at_edge(r + 28); chk("p_up28", up, 0);
    at_edge(r + 29); chk("p_out29", out_aresetn, 4'hF); chk("p_st29", stage, 4);
    chk("p_flags29", {up, down, busy}, 3'b100);
    // Shutdown sampled at r+100.
    at_edge(r + 99); req_run = 1'b0;
    at_edge(r + 102); chk("f_out102", out_aresetn, 4'hF);
    at_edge(r + 103); chk("f_out103", out_aresetn, 4'h7); chk("f_busy103", busy, 1);
    at_edge(r + 112); chk("f_out112", out_aresetn, 4'h0); chk("f_st112", stage, 0);
    at_edge(r + 127); chk("f_down127", down, 0);
    at_edge(r + 128); chk("f_down128", down, 1);
    // Reversal at stage 2, then a raise during HOLD.
    e0 = r + 130;
    at_edge(e0 - 1); req_run = 1'b1;
    at_edge(e0 + 6); chk("v_out6", out_aresetn, 4'h3); req_run = 1'b0;
    at_edge(e0 + 9);  chk("v_out9", out_aresetn, 4'h3);
    at_edge(e0 + 10); chk("v_out10", out_aresetn, 4'h1);
    at_edge(e0 + 13); chk("v_out13", out_aresetn, 4'h0);
    at_edge(e0 + 14); req_run = 1'b1;
    at_edge(e0 + 28); chk("v_hold28", {out_aresetn, down}, 5'h0);
    at_edge(e0 + 29); chk("v_down29", down, 1);
    at_edge(e0 + 32); chk("v_out32", out_aresetn, 4'h0);
    at_edge(e0 + 33); chk("v_out33", out_aresetn, 4'h1); req_run = 1'b0;
    at_edge(e0 + 37); chk("v_out37", out_aresetn, 4'h0);
    at_edge(e0 + 53); chk("v_down53", down, 1);
    // Drop before the first release: straight back to HOLD.
    f = e0 + 55;
    at_edge(f - 1); req_run = 1'b1;
    at_edge(f);     req_run = 1'b0;
    at_edge(f + 4);  chk("z_out4", {out_aresetn, busy}, 5'h01);
    at_edge(f + 16); chk("z_down16", down, 0);
    at_edge(f + 17); chk("z_down17", down, 1);
    // step_delay=0 spaces steps one cycle apart.
    g = f + 20;
    at_edge(g - 1); step_delay = '0; req_run = 1'b1;
    at_edge(g + 1); chk("d0_out1", out_aresetn, 4'h1);
    at_edge(g + 2); chk("d0_out2", out_aresetn, 4'h3);
    at_edge(g + 3); chk("d0_out3", out_aresetn, 4'h7);
    at_edge(g + 4); chk("d0_out4", {out_aresetn, up}, 5'h1F);
    at_edge(g + 6); req_run = 1'b0;
    at_edge(g + 8);  chk("d0_fall8", out_aresetn, 4'h7);
    at_edge(g + 11); chk("d0_fall11", out_aresetn, 4'h0);
    at_edge(g + 27); chk("d0_down27", down, 1);
    // Delay change mid-step only affects the next load.
    h = g + 30;
    at_edge(h - 1); step_delay = 16'd4; req_run = 1'b1;
    at_edge(h);     step_delay = 16'd2;
    at_edge(h + 3); chk("m_out3", out_aresetn, 4'h0);
    at_edge(h + 4); chk("m_out4", out_aresetn, 4'h1);
    at_edge(h + 6); chk("m_out6", out_aresetn, 4'h3); step_delay = 16'd5;
    // Asynchronous reset mid-RISE.
    s = h + 7 + int'($urandom_range(0, 4));
    at_edge(s);
    #3 aresetn = 1'b0;
    #1;
    chk("ar_out", out_aresetn, 0);
    chk("ar_stage", stage, 0);
    chk("ar_flags", {up, down, busy}, 3'b001);
    at_edge(s + 1);
    aresetn = 1'b1;
    r2 = ecount;
    at_edge(r2 + 15); chk("ar_hold15", down, 0);
    at_edge(r2 + 16); chk("ar_down16", down, 1);
    at_edge(r2 + 21); chk("ar_out21", out_aresetn, 4'h0);
    at_edge(r2 + 22); chk("ar_out22", out_aresetn, 4'h1);
    at_edge(r2 + 30);
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
